// File: rtl/interrupt_injector.sv
// interrupt_injector
//   CPU-side 6502 interrupt sequencer. At an opcode-fetch boundary it accepts
//   a pending NMI (priority) or an unmasked IRQ, then walks the 7-cycle
//   interrupt sequence: boundary/accept, dummy fetch (T_ACK), push PCH,
//   push PCL, push P, vector low, vector high.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   enable            cycle enable; low freezes state and kills strobes
//   instr_boundary    current cycle is the SYNC (opcode fetch) cycle
//   nmi_pending       pending-NMI flag from the edge-detect flop
//   irq_level         synchronized IRQ request, active high
//   i_flag            processor status I bit
//   interrupt_ack     one-cycle acknowledge of an accepted NMI
//   inject_active     sequence in progress (decoder suppresses opcode)
//   nmi_running       NMI handler in progress
//   push_en/push_sel  stack write strobe and source (00 PCH, 01 PCL, 10 P)
//   vector_rd/addr    vector byte read strobe and address
//   load_pcl/load_pch latch read byte into PC low/high
//   set_i             set the I flag (with load_pch)
module interrupt_injector #(
  parameter logic [15:0] NMI_VECTOR = 16'hFFFA,
  parameter logic [15:0] IRQ_VECTOR = 16'hFFFE,
  parameter bit          HIJACK_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        instr_boundary,
  input  logic        nmi_pending,
  input  logic        irq_level,
  input  logic        i_flag,
  output logic        interrupt_ack,
  output logic        inject_active,
  output logic        nmi_running,
  output logic        push_en,
  output logic [1:0]  push_sel,
  output logic        vector_rd,
  output logic [15:0] vector_addr,
  output logic        load_pcl,
  output logic        load_pch,
  output logic        set_i
);

  typedef enum logic [2:0] {
    IDLE, T_ACK, T_PCH, T_PCL, T_P, T_VLO, T_VHI
  } state_t;

  state_t      state, stateNxt;
  logic        isNmi, isNmiNxt;
  logic        nmiRunNxt;
  logic        accept, hijack;
  logic [15:0] vec;

  assign vec = isNmi ? NMI_VECTOR : IRQ_VECTOR;

  assign accept = enable && (state == IDLE) && instr_boundary &&
                  (nmi_pending || (irq_level && !i_flag));

  // An NMI that shows up before the vector fetch starts steals the vector;
  // once T_VLO has begun the low byte is already committed, so it waits.
  assign hijack = HIJACK_EN && enable && !isNmi && nmi_pending &&
                  (state inside {T_ACK, T_PCH, T_PCL, T_P});

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      isNmi       <= 1'b0;
      nmi_running <= 1'b0;
    end else begin
      state       <= stateNxt;
      isNmi       <= isNmiNxt;
      nmi_running <= nmiRunNxt;
    end
  end

  always_comb begin
    stateNxt      = state;
    isNmiNxt      = isNmi;
    interrupt_ack = 1'b0;
    push_en       = 1'b0;
    push_sel      = 2'b00;
    vector_rd     = 1'b0;
    vector_addr   = IRQ_VECTOR;
    load_pcl      = 1'b0;
    load_pch      = 1'b0;
    set_i         = 1'b0;
    inject_active = (state != IDLE);

    case (state)
      IDLE: begin
        if (accept) begin
          stateNxt = T_ACK;
          isNmiNxt = nmi_pending;  // NMI wins over IRQ
        end
      end
      T_ACK: begin
        interrupt_ack = enable && isNmi;
        if (enable) stateNxt = T_PCH;
      end
      T_PCH: begin
        push_en  = enable;
        push_sel = 2'b00;
        if (enable) stateNxt = T_PCL;
      end
      T_PCL: begin
        push_en  = enable;
        push_sel = 2'b01;
        if (enable) stateNxt = T_P;
      end
      T_P: begin
        push_en  = enable;
        push_sel = 2'b10;
        if (enable) stateNxt = T_VLO;
      end
      T_VLO: begin
        vector_rd   = enable;
        vector_addr = vec;
        load_pcl    = enable;
        if (enable) stateNxt = T_VHI;
      end
      T_VHI: begin
        vector_rd   = enable;
        vector_addr = vec + 16'd1;  // wraps FFFF -> 0000
        load_pch    = enable;
        set_i       = enable;
        if (enable) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase

    // hijack only fires while isNmi=0, so at most one ack per sequence
    if (hijack) begin
      isNmiNxt      = 1'b1;
      interrupt_ack = 1'b1;
    end

    // set beats clear; clear means the handler returned (I=0 back in IDLE)
    nmiRunNxt = nmi_running;
    if ((enable && (state == T_ACK) && isNmi) || hijack)
      nmiRunNxt = 1'b1;
    else if (enable && (state == IDLE) && !i_flag && !accept)
      nmiRunNxt = 1'b0;
  end

endmodule

// File: tb/tb_interrupt_injector.sv
// Directed bench for interrupt_injector. Two instances share stimulus:
// dut1 with hijack enabled, dut2 with hijack disabled. Outputs are packed
// into one vector per instance and compared against hand-derived values.
module tb_interrupt_injector;

  logic clk = 1'b0;
  logic rst, enable, instrBoundary, nmiPending, irqLevel, iFlag;

  logic        ack1, act1, run1, pe1, vr1, lpl1, lph1, si1;
  logic [1:0]  ps1;
  logic [15:0] va1;
  logic        ack2, act2, run2, pe2, vr2, lpl2, lph2, si2;
  logic [1:0]  ps2;
  logic [15:0] va2;

  int nVec = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  interrupt_injector #(.NMI_VECTOR(16'hFFFA), .IRQ_VECTOR(16'hFFFE), .HIJACK_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .instr_boundary(instrBoundary),
    .nmi_pending(nmiPending), .irq_level(irqLevel), .i_flag(iFlag),
    .interrupt_ack(ack1), .inject_active(act1), .nmi_running(run1),
    .push_en(pe1), .push_sel(ps1), .vector_rd(vr1), .vector_addr(va1),
    .load_pcl(lpl1), .load_pch(lph1), .set_i(si1));

  interrupt_injector #(.NMI_VECTOR(16'hFFFA), .IRQ_VECTOR(16'hFFFE), .HIJACK_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .instr_boundary(instrBoundary),
    .nmi_pending(nmiPending), .irq_level(irqLevel), .i_flag(iFlag),
    .interrupt_ack(ack2), .inject_active(act2), .nmi_running(run2),
    .push_en(pe2), .push_sel(ps2), .vector_rd(vr2), .vector_addr(va2),
    .load_pcl(lpl2), .load_pch(lph2), .set_i(si2));

  wire [25:0] obs1 = {ack1, act1, run1, pe1, ps1, vr1, va1, lpl1, lph1, si1};
  wire [25:0] obs2 = {ack2, act2, run2, pe2, ps2, vr2, va2, lpl2, lph2, si2};

  function automatic logic [25:0] E(logic ack, logic act, logic run, logic pe,
                                    logic [1:0] ps, logic vr, logic [15:0] va,
                                    logic lpl, logic lph, logic si);
    return {ack, act, run, pe, ps, vr, va, lpl, lph, si};
  endfunction

  // IDLE: everything quiet, address parked on the IRQ vector
  function automatic logic [25:0] I(logic run);
    return E(1'b0, 1'b0, run, 1'b0, 2'b00, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
  endfunction

  // idx 0..5 = T_ACK, T_PCH, T_PCL, T_P, T_VLO, T_VHI
  function automatic logic [25:0] S(int idx, logic en, logic ack, logic run, logic [15:0] vec);
    logic [1:0]  ps;
    logic [15:0] va;
    ps = (idx == 2) ? 2'b01 : (idx == 3) ? 2'b10 : 2'b00;
    va = (idx == 4) ? vec : (idx == 5) ? vec + 16'd1 : 16'hFFFE;
    return E(ack, 1'b1, run, en && (idx >= 1) && (idx <= 3), ps, en && (idx >= 4), va,
             en && (idx == 4), en && (idx == 5), en && (idx == 5));
  endfunction

  task automatic chk(input string tag, input logic [25:0] e1, input logic [25:0] e2);
    #1;
    nVec++;
    assert (obs1 === e1) else begin
      nMis++;
      $error("FAIL %s dut1 observed=%h expected=%h", tag, obs1, e1);
    end
    nVec++;
    assert (obs2 === e2) else begin
      nMis++;
      $error("FAIL %s dut2 observed=%h expected=%h", tag, obs2, e2);
    end
  endtask

  task automatic chkB(input string tag, input logic [25:0] e);
    chk(tag, e, e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // starts in T_ACK with enable=1; drops nmiPending once T_ACK is done
  task automatic seqRun(input string tag, input logic ackAt0, input logic r0a,
                        input logic r0b, input logic rRest, input logic [15:0] vec);
    for (int i = 0; i < 6; i++) begin
      if (i == 1) nmiPending = 1'b0;
      chk($sformatf("%s s%0d", tag, i),
          S(i, 1'b1, (i == 0) ? ackAt0 : 1'b0, (i == 0) ? r0a : rRest, vec),
          S(i, 1'b1, (i == 0) ? ackAt0 : 1'b0, (i == 0) ? r0b : rRest, vec));
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; instrBoundary = 1'b0;
    nmiPending = 1'b0; irqLevel = 1'b0; iFlag = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chkB("reset", I(1'b0));

    // IRQ sequence; irq drops after acceptance and must not abort
    irqLevel = 1'b1; iFlag = 1'b0; instrBoundary = 1'b1;
    chkB("irq accept", I(1'b0));
    tick();
    instrBoundary = 1'b0; irqLevel = 1'b0;
    seqRun("irq", 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFE);
    chkB("irq done", I(1'b0));

    // NMI and IRQ together: NMI wins
    nmiPending = 1'b1; irqLevel = 1'b1; iFlag = 1'b0; instrBoundary = 1'b1;
    chkB("nmi accept", I(1'b0));
    tick();
    instrBoundary = 1'b0; irqLevel = 1'b0; iFlag = 1'b1;
    seqRun("nmi", 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFA);
    chkB("nmi run held", I(1'b1));
    tick();
    chkB("nmi run held2", I(1'b1));
    iFlag = 1'b0;
    tick();
    chkB("nmi run clr", I(1'b0));

    // NMI arrives in T_PCL of an IRQ sequence: dut1 hijacks, dut2 does not
    irqLevel = 1'b1; instrBoundary = 1'b1;
    chkB("hj accept", I(1'b0));
    tick();
    instrBoundary = 1'b0; irqLevel = 1'b0; iFlag = 1'b1;
    chkB("hj s0", S(0, 1'b1, 1'b0, 1'b0, 16'hFFFE));
    tick();
    chkB("hj s1", S(1, 1'b1, 1'b0, 1'b0, 16'hFFFE));
    tick();
    nmiPending = 1'b1;
    chk("hj s2", S(2, 1'b1, 1'b1, 1'b0, 16'hFFFA), S(2, 1'b1, 1'b0, 1'b0, 16'hFFFE));
    tick();
    chk("hj s3", S(3, 1'b1, 1'b0, 1'b1, 16'hFFFA), S(3, 1'b1, 1'b0, 1'b0, 16'hFFFE));
    tick();
    chk("hj s4", S(4, 1'b1, 1'b0, 1'b1, 16'hFFFA), S(4, 1'b1, 1'b0, 1'b0, 16'hFFFE));
    tick();
    chk("hj s5", S(5, 1'b1, 1'b0, 1'b1, 16'hFFFA), S(5, 1'b1, 1'b0, 1'b0, 16'hFFFE));
    tick();
    // still-pending NMI is taken at the next boundary
    instrBoundary = 1'b1;
    chk("hj idle", I(1'b1), I(1'b0));
    tick();
    instrBoundary = 1'b0;
    seqRun("hj nmi", 1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFA);
    chkB("hj end", I(1'b1));
    iFlag = 1'b0;
    tick();
    chkB("hj run clr", I(1'b0));

    // NMI with enable low every other cycle
    nmiPending = 1'b1; instrBoundary = 1'b1; iFlag = 1'b1;
    chkB("stall accept", I(1'b0));
    tick();
    instrBoundary = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) nmiPending = 1'b0;
      enable = 1'b0;
      chkB($sformatf("stall off s%0d", i), S(i, 1'b0, 1'b0, i != 0, 16'hFFFA));
      tick();
      enable = 1'b1;
      chkB($sformatf("stall on s%0d", i), S(i, 1'b1, i == 0, i != 0, 16'hFFFA));
      tick();
    end
    chkB("stall end", I(1'b1));
    iFlag = 1'b0;
    tick();

    // masked IRQ is ignored
    iFlag = 1'b1; irqLevel = 1'b1; instrBoundary = 1'b1;
    chkB("masked a", I(1'b0));
    tick();
    chkB("masked b", I(1'b0));
    irqLevel = 1'b0; instrBoundary = 1'b0;

    // reset in T_P, then a fresh NMI
    nmiPending = 1'b1; instrBoundary = 1'b1;
    tick();
    instrBoundary = 1'b0;
    chkB("rst s0", S(0, 1'b1, 1'b1, 1'b0, 16'hFFFA));
    tick();
    nmiPending = 1'b0;
    chkB("rst s1", S(1, 1'b1, 1'b0, 1'b1, 16'hFFFA));
    tick();
    chkB("rst s2", S(2, 1'b1, 1'b0, 1'b1, 16'hFFFA));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkB("rst idle", I(1'b0));
    nmiPending = 1'b1; instrBoundary = 1'b1;
    chkB("rst re-accept", I(1'b0));
    tick();
    instrBoundary = 1'b0;
    seqRun("rst nmi", 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFA);
    chkB("rst end", I(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
